burst_pingpong_decimator: RTL and testbench

BURST_PINGPONG_DECIMATOR -- requirements
Module: burst_pingpong_decimator

---
 rtl/burst_pingpong_decimator.sv | 239 +++++++++++++++++++++++
 tb/tb_burst_pingpong_decimator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_pingpong_decimator.sv
// Burst ping-pong decimator: keeps every DECIM-th I/Q sample, packs kept
// samples into two alternating banks of BURST_LEN entries and streams each
// full bank out over a valid/ready interface. Samples that arrive while the
// target bank is still waiting to be drained are dropped and counted.
module burst_pingpong_decimator #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST_LEN  = 2048,
    parameter int DECIM      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_q,
    input  logic                         in_valid,
    input  logic                         in_first,
    output logic signed [DATA_WIDTH-1:0] out_data_i,
    output logic signed [DATA_WIDTH-1:0] out_data_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         overflow,
    output logic        [CNT_WIDTH-1:0]  drop_count,
    output logic        [1:0]            bank_full
);

    localparam int AW = $clog2(BURST_LEN);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [AW-1:0] LAST_IDX   = AW'(BURST_LEN - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } rd_state_t;

    // Decimation phase advance, wrapping after DECIM-1.
    function automatic logic [PW-1:0] phase_step(input logic [PW-1:0] p);
        if (p == LAST_PHASE) begin
            phase_step = '0;
        end else begin
            phase_step = p + 1'b1;
        end
    endfunction

    // Saturating increment: sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) begin
            sat_inc = c;
        end else begin
            sat_inc = c + 1'b1;
        end
    endfunction

    // Two banks share one array; the bank index is the address MSB.
    logic signed [DATA_WIDTH-1:0] mem_i [0:2*BURST_LEN-1];
    logic signed [DATA_WIDTH-1:0] mem_q [0:2*BURST_LEN-1];

    // Write side
    logic [PW-1:0]        phase_q, phase_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, wr_ptr_eff;
    logic                 wr_bank_q, wr_bank_d;
    logic                 keep, wr_en;
    logic [1:0]           fill_set;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

    // Read side
    rd_state_t                    rd_state_q, rd_state_d;
    logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
    logic                         rd_bank_q, rd_bank_d;
    logic [1:0]                   rel_clr;
    logic [1:0]                   avail;
    logic                         accept;
    logic signed [DATA_WIDTH-1:0] dout_i_q, dout_i_d;
    logic signed [DATA_WIDTH-1:0] dout_q_q, dout_q_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;

    assign accept = out_valid_q && out_ready;
    // A bank completing this cycle counts as available so the reader can
    // prime immediately, giving first out_valid two cycles after the fill.
    assign avail  = bank_full_q | fill_set;

    // Writer: decimation, bank packing, overflow detection.
    always_comb begin
        keep         = in_valid && (in_first || (phase_q == '0));
        wr_ptr_eff   = in_first ? '0 : wr_ptr_q;
        phase_d      = phase_q;
        wr_ptr_d     = wr_ptr_q;
        wr_bank_d    = wr_bank_q;
        wr_en        = 1'b0;
        fill_set     = 2'b00;
        overflow_d   = 1'b0;
        drop_count_d = drop_count_q;
        if (in_valid) begin
            phase_d = in_first ? phase_step('0) : phase_step(phase_q);
        end
        if (keep) begin
            if (bank_full_q[wr_bank_q]) begin
                overflow_d   = 1'b1;
                drop_count_d = sat_inc(drop_count_q);
            end else begin
                wr_en = 1'b1;
                if (wr_ptr_eff == LAST_IDX) begin
                    fill_set[wr_bank_q] = 1'b1;
                    wr_bank_d           = ~wr_bank_q;
                    wr_ptr_d            = '0;
                end else begin
                    wr_ptr_d = wr_ptr_eff + 1'b1;
                end
            end
        end
        // Fill and release always target different banks, so both apply.
        bank_full_d = (bank_full_q | fill_set) & ~rel_clr;
    end

    // Reader next-state: wait for a full bank, prime the RAM read, stream.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            IDLE: begin
                if (avail[rd_bank_q]) begin
                    rd_state_d = PRIME;
                end
            end
            PRIME: begin
                rd_state_d = STREAM;
            end
            STREAM: begin
                if (accept && out_last_q) begin
                    rd_state_d = IDLE;
                end
            end
            default: begin
                rd_state_d = IDLE;
            end
        endcase
    end

    // Reader outputs: load the output register from RAM on prime or accept,
    // hold it while stalled, release the bank after its last sample.
    always_comb begin
        dout_i_d    = dout_i_q;
        dout_q_d    = dout_q_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        rd_ptr_d    = rd_ptr_q;
        rd_bank_d   = rd_bank_q;
        rel_clr     = 2'b00;
        case (rd_state_q)
            PRIME: begin
                dout_i_d    = mem_i[{rd_bank_q, rd_ptr_q}];
                dout_q_d    = mem_q[{rd_bank_q, rd_ptr_q}];
                out_valid_d = 1'b1;
                out_last_d  = (rd_ptr_q == LAST_IDX);
                rd_ptr_d    = rd_ptr_q + 1'b1;
            end
            STREAM: begin
                if (accept) begin
                    if (out_last_q) begin
                        out_valid_d        = 1'b0;
                        out_last_d         = 1'b0;
                        rd_ptr_d           = '0;
                        rd_bank_d          = ~rd_bank_q;
                        rel_clr[rd_bank_q] = 1'b1;
                    end else begin
                        dout_i_d    = mem_i[{rd_bank_q, rd_ptr_q}];
                        dout_q_d    = mem_q[{rd_bank_q, rd_ptr_q}];
                        out_valid_d = 1'b1;
                        out_last_d  = (rd_ptr_q == LAST_IDX);
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Reader FSM state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rd_state_q <= IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    // Control and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            phase_q      <= '0;
            wr_ptr_q     <= '0;
            wr_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            rd_ptr_q     <= '0;
            rd_bank_q    <= 1'b0;
            dout_i_q     <= '0;
            dout_q_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_bank_q    <= wr_bank_d;
            bank_full_q  <= bank_full_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_bank_q    <= rd_bank_d;
            dout_i_q     <= dout_i_d;
            dout_q_q     <= dout_q_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    // Sample storage; contents survive reset and are simply overwritten.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_i[{wr_bank_q, wr_ptr_eff}] <= in_data_i;
            mem_q[{wr_bank_q, wr_ptr_eff}] <= in_data_q;
        end
    end

    assign out_data_i = dout_i_q;
    assign out_data_q = dout_q_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign bank_full  = bank_full_q;

endmodule

// File: tb/tb_burst_pingpong_decimator.sv
// Bench for burst_pingpong_decimator with BURST_LEN=8, DECIM=2. A writer-side
// model pushes expected bank contents into a queue; a monitor pops and
// compares on every accepted output. A second instance with a 4-bit drop
// counter shares the stimulus to exercise counter saturation.
module tb_burst_pingpong_decimator;

    localparam int DW  = 12;
    localparam int BL  = 8;
    localparam int DEC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_i, in_q;
    logic          in_valid, in_first, out_ready;
    logic [DW-1:0] out_i, out_q;
    logic          out_valid, out_last, overflow;
    logic [15:0]   drop_count;
    logic [1:0]    bank_full;
    logic [DW-1:0] s_out_i, s_out_q;
    logic          s_valid, s_last, s_ovf;
    logic [3:0]    s_drop;
    logic [1:0]    s_full;

    burst_pingpong_decimator #(.DATA_WIDTH(DW), .BURST_LEN(BL), .DECIM(DEC), .CNT_WIDTH(16)) dut (
        .clk_in(clk), .rst(rst), .in_data_i(in_i), .in_data_q(in_q),
        .in_valid(in_valid), .in_first(in_first),
        .out_data_i(out_i), .out_data_q(out_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .overflow(overflow),
        .drop_count(drop_count), .bank_full(bank_full)
    );

    burst_pingpong_decimator #(.DATA_WIDTH(DW), .BURST_LEN(BL), .DECIM(DEC), .CNT_WIDTH(4)) dut4 (
        .clk_in(clk), .rst(rst), .in_data_i(in_i), .in_data_q(in_q),
        .in_valid(in_valid), .in_first(in_first),
        .out_data_i(s_out_i), .out_data_q(s_out_q), .out_valid(s_valid),
        .out_ready(out_ready), .out_last(s_last), .overflow(s_ovf),
        .drop_count(s_drop), .bank_full(s_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        logic          last;
    } exp_t;

    typedef struct {
        int n_in;      // inputs driven, data = index
        int first_at;  // index carrying in_first, -1 for none
        int mode;      // 0 ready high, 1 ready toggling, 2 ready low until inputs end
        int full_at;   // index after which bank_full is checked, -1 for none
        int full_exp;
        int lat_chk;   // check first-output latency against input 14
        int exp_outs;
        int exp_drops;
    } scen_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   m_phase, m_cnt, m_out;
    int   m_buf[BL];
    int   pops, ovf_seen, first_vld_cyc, wr14_cyc;
    logic prev_stall;
    logic [2*DW:0] prev_word;

    function automatic void check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    function automatic logic [DW-1:0] mkq(input int n);
        return DW'(12'hFFF ^ n[DW-1:0]);
    endfunction

    function automatic void clear_model();
        exp_q.delete();
        m_phase = 0; m_cnt = 0; m_out = 0;
        pops = 0; ovf_seen = 0; first_vld_cyc = -1;
    endfunction

    // Writer model: decimate, align on first, pack banks, predict drops.
    function automatic void model_in(input int n, input bit first);
        bit kept;
        kept = first || (m_phase == 0);
        m_phase = first ? (1 % DEC) : ((m_phase + 1) % DEC);
        if (first) m_cnt = 0;
        if (kept && m_out < 2) begin
            m_buf[m_cnt] = n;
            m_cnt++;
            if (m_cnt == BL) begin
                for (int k = 0; k < BL; k++) begin
                    exp_t e;
                    e.i = DW'(m_buf[k]);
                    e.q = mkq(m_buf[k]);
                    e.last = (k == BL - 1);
                    exp_q.push_back(e);
                end
                m_cnt = 0;
                m_out++;
            end
        end
    endfunction

    task automatic drive(input int n, input bit first);
        @(posedge clk); #1;
        in_valid = 1'b1; in_first = first;
        in_i = DW'(n); in_q = mkq(n);
        model_in(n, first);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'($urandom_range(0, 1));
        in_i = DW'($urandom); in_q = DW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_out_i"}, out_i, 0);
        check({tag, "_out_q"}, out_q, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        check({tag, "_bank_full"}, bank_full, 0);
        check({tag, "_drop_count4"}, s_drop, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0;
        #1;
        check_reset_outputs("reset");
        clear_model();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int mode);
        int budget;
        budget = 0;
        if (mode == 2) out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && budget < 300) begin
            idle_cycle();
            if (mode == 1) out_ready = ~out_ready;
            budget++;
        end
        check("drain_within_budget", budget < 300, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) idle_cycle();
    endtask

    // Cycle counter for latency measurement.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Output monitor: scoreboard pop, stall stability, overflow count.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (overflow) ovf_seen++;
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", {out_i, out_q, out_last}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_output: got data %0d, expected no output", out_i);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data_i", out_i, e.i);
                    check("out_data_q", out_q, e.q);
                    check("out_last", out_last, e.last);
                    if (e.last) m_out--;
                    pops++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_i, out_q, out_last};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        scen_t tbl[5];
        tbl[0] = '{n_in:16, first_at:-1, mode:0, full_at:15, full_exp:1, lat_chk:1, exp_outs:8,  exp_drops:0};
        tbl[1] = '{n_in:32, first_at:-1, mode:1, full_at:-1, full_exp:0, lat_chk:0, exp_outs:16, exp_drops:0};
        tbl[2] = '{n_in:21, first_at:5,  mode:0, full_at:-1, full_exp:0, lat_chk:0, exp_outs:8,  exp_drops:0};
        tbl[3] = '{n_in:48, first_at:-1, mode:2, full_at:31, full_exp:3, lat_chk:0, exp_outs:16, exp_drops:8};
        tbl[4] = '{n_in:88, first_at:-1, mode:2, full_at:31, full_exp:3, lat_chk:0, exp_outs:16, exp_drops:28};

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        in_i = '0; in_q = '0; prev_stall = 1'b0; prev_word = '0; wr14_cyc = 0;
        clear_model();

        for (int s = 0; s < 5; s++) begin
            do_reset();
            out_ready = (tbl[s].mode != 2);
            for (int n = 0; n < tbl[s].n_in; n++) begin
                drive(n, n == tbl[s].first_at);
                if (tbl[s].mode == 1) out_ready = ~out_ready;
                if (n == 14) wr14_cyc = cyc;
                if (n == tbl[s].full_at) begin
                    @(negedge clk);
                    check("bank_full_flags", bank_full, tbl[s].full_exp);
                end
            end
            drain(tbl[s].mode);
            check("output_count", pops, tbl[s].exp_outs);
            check("overflow_pulses", ovf_seen, tbl[s].exp_drops);
            check("drop_count", drop_count, tbl[s].exp_drops);
            check("drop_count_sat4", s_drop, (tbl[s].exp_drops > 15) ? 15 : tbl[s].exp_drops);
            check("bank_full_after_drain", bank_full, 0);
            if (tbl[s].lat_chk != 0) check("first_valid_latency", first_vld_cyc - wr14_cyc, 2);
        end

        // Reset while output index 3 is being presented.
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 19; n++) drive(n, 1'b0);
        idle_cycle();
        check("mid_drain_outputs_before_reset", pops, 3);
        check("mid_drain_valid_before_reset", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_drain_reset");
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 16; n++) drive(100 + n, 1'b0);
        drain(0);
        check("post_reset_output_count", pops, 8);
        check("post_reset_drop_count", drop_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
